// File: rtl/predictor_update_ctrl_pkg.sv
// Shared encodings for the branch-history maintenance controller: 2-bit
// counter values and the maintenance FSM states.
package predictor_update_ctrl_pkg;

  localparam int PREDICTOR_BIT = 2;

  localparam logic [1:0] STRONG_NOT_JUMP = 2'b00;
  localparam logic [1:0] WEAK_NOT_JUMP   = 2'b01;
  localparam logic [1:0] WEAK_JUMP       = 2'b10;
  localparam logic [1:0] STRONG_JUMP     = 2'b11;

  typedef enum logic [1:0] {
    PUC_INIT  = 2'd0,
    PUC_IDLE  = 2'd1,
    PUC_READ  = 2'd2,
    PUC_WRITE = 2'd3
  } puc_state_e;

endpackage

// File: rtl/predictor_update_ctrl_fifo.sv
// Small synchronous FIFO that holds committed branch outcomes until the
// maintenance port is free. Storage is not reset; only pointers and count are.
module pdt_update_fifo
  import predictor_update_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/predictor_update_ctrl.sv
// Owns the predictor table's maintenance port: clears it by sweep after reset,
// then applies queued ROB branch outcomes as read-modify-write counter updates.
module predictor_update_ctrl
  import predictor_update_ctrl_pkg::*;
#(
  parameter int         PREDICTOR_SIZE = 256,
  parameter int         IDX_W          = 8,
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [1:0] INIT_VALUE     = WEAK_NOT_JUMP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_sign_from_rob,
  input  logic             hit_from_rob,
  input  logic [31:0]      pc_from_rob,
  output logic             full_to_rob,
  output logic             ready_to_fch,
  output logic [IDX_W-1:0] tbl_addr_to_pdt,
  output logic             tbl_we_to_pdt,
  output logic [1:0]       tbl_wdata_to_pdt,
  input  logic [1:0]       tbl_rdata_from_pdt,
  output logic             overflow_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PREDICTOR_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  puc_state_e       state;
  logic [IDX_W-1:0] sweep_idx;
  logic [IDX_W-1:0] addr_q;
  logic [1:0]       wdata_q;
  logic             push_acc;
  logic             pop_head;
  logic [IDX_W:0]   head;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             more_after_pop;
  logic [1:0]       upd_val;
  logic             unused_pc_bits;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == STRONG_JUMP)     ? STRONG_JUMP     : ctr + 2'd1;
    else       return (ctr == STRONG_NOT_JUMP) ? STRONG_NOT_JUMP : ctr - 2'd1;
  endfunction

  assign unused_pc_bits = ^{pc_from_rob[31:IDX_W+2], pc_from_rob[1:0]};
  assign push_acc       = enable_sign_from_rob && !full_to_rob;
  assign pop_head       = (state == PUC_WRITE);
  assign head_idx       = head[IDX_W:1];
  assign head_taken     = head[0];
  assign more_after_pop = (fifo_count > CNT_ONE) || push_acc;
  assign upd_val        = sat_update(tbl_rdata_from_pdt, head_taken);

  pdt_update_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (IDX_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_acc),
    .pop   (pop_head),
    .din   ({pc_from_rob[IDX_W+1:2], hit_from_rob}),
    .dout  (head),
    .count (fifo_count),
    .full  (full_to_rob),
    .empty (fifo_empty)
  );

  // READ/WRITE address follows the queue head; write data in WRITE depends on
  // this cycle's read data, so it cannot be registered without a third cycle.
  assign tbl_addr_to_pdt  = (state == PUC_READ || state == PUC_WRITE) ? head_idx : addr_q;
  assign tbl_wdata_to_pdt = (state == PUC_WRITE) ? upd_val : wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= PUC_INIT;
      sweep_idx     <= '0;
      addr_q        <= '0;
      wdata_q       <= INIT_VALUE;
      tbl_we_to_pdt <= 1'b0;
      ready_to_fch  <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      if (enable_sign_from_rob && full_to_rob) overflow_err <= 1'b1;
      case (state)
        PUC_INIT: begin
          tbl_we_to_pdt <= 1'b1;
          addr_q        <= sweep_idx;
          wdata_q       <= INIT_VALUE;
          sweep_idx     <= sweep_idx + IDX_W'(1);
          if (sweep_idx == LAST_IDX) begin
            state        <= PUC_IDLE;
            ready_to_fch <= 1'b1;
          end
        end
        PUC_IDLE: begin
          tbl_we_to_pdt <= 1'b0;
          if (!fifo_empty) state <= PUC_READ;
        end
        PUC_READ: begin
          tbl_we_to_pdt <= 1'b1;
          state         <= PUC_WRITE;
        end
        PUC_WRITE: begin
          tbl_we_to_pdt <= 1'b0;
          wdata_q       <= upd_val;
          state         <= more_after_pop ? PUC_READ : PUC_IDLE;
        end
        default: state <= PUC_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_predictor_update_ctrl.sv
// Scoreboard bench: expected table writes are queued as stimulus is issued and
// a negedge monitor checks every write strobe the controller presents.
module tb_predictor_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_sign_from_rob;
  logic        hit_from_rob;
  logic [31:0] pc_from_rob;
  logic        full_to_rob;
  logic        ready_to_fch;
  logic [7:0]  tbl_addr_to_pdt;
  logic        tbl_we_to_pdt;
  logic [1:0]  tbl_wdata_to_pdt;
  logic [1:0]  tbl_rdata_from_pdt;
  logic        overflow_err;

  always #5 clk = ~clk;

  predictor_update_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable_sign_from_rob (enable_sign_from_rob),
    .hit_from_rob         (hit_from_rob),
    .pc_from_rob          (pc_from_rob),
    .full_to_rob          (full_to_rob),
    .ready_to_fch         (ready_to_fch),
    .tbl_addr_to_pdt      (tbl_addr_to_pdt),
    .tbl_we_to_pdt        (tbl_we_to_pdt),
    .tbl_wdata_to_pdt     (tbl_wdata_to_pdt),
    .tbl_rdata_from_pdt   (tbl_rdata_from_pdt),
    .overflow_err         (overflow_err)
  );

  // Predictor table model: synchronous read of last cycle's address.
  logic [1:0] tbl [0:255];
  initial for (int i = 0; i < 256; i++) tbl[i] = 2'b11;
  always @(posedge clk) begin
    tbl_rdata_from_pdt <= tbl[tbl_addr_to_pdt];
    if (tbl_we_to_pdt) tbl[tbl_addr_to_pdt] <= tbl_wdata_to_pdt;
  end

  typedef struct packed {
    logic [7:0] addr;
    logic [1:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && tbl_we_to_pdt === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0d data %b, expected no write at %0t",
                 tbl_addr_to_pdt, tbl_wdata_to_pdt, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", tbl_addr_to_pdt, mon_e.addr);
        chk("wr_data", tbl_wdata_to_pdt, mon_e.data);
      end
    end
  end

  task automatic expect_wr(input logic [7:0] a, input logic [1:0] d);
    sb.push_back('{addr: a, data: d});
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 256; i++) expect_wr(8'(i), 2'b01);
  endtask

  task automatic commit(input logic [31:0] pc, input logic hit);
    enable_sign_from_rob = 1'b1;
    pc_from_rob          = pc;
    hit_from_rob         = hit;
    @(posedge clk);
    #1;
    enable_sign_from_rob = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, ready_to_fch, 0);
    chk({tag, "_full"},  full_to_rob, 0);
    chk({tag, "_we"},    tbl_we_to_pdt, 0);
    chk({tag, "_addr"},  tbl_addr_to_pdt, 0);
    chk({tag, "_wdata"}, tbl_wdata_to_pdt, 2'b01);
    chk({tag, "_ovf"},   overflow_err, 0);
  endtask

  task automatic wait_ready();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ready_to_fch) got = 1'b1;
    end
    chk("ready_wait", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                  = 1'b0;
    enable_sign_from_rob = 1'b0;
    hit_from_rob         = 1'b0;
    pc_from_rob          = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");

    // Sweep with two commits queued during INIT, drained right after ready.
    push_sweep();
    @(negedge clk) rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    expect_wr(8'd20, 2'b10);
    expect_wr(8'd21, 2'b00);
    commit(32'h0000_0050, 1'b1);
    commit(32'h0000_0054, 1'b0);
    chk("init_not_ready", ready_to_fch, 0);
    wait_ready();
    chk("ready_last_we",   tbl_we_to_pdt, 1);
    chk("ready_last_addr", tbl_addr_to_pdt, 255);
    @(posedge clk);
    #1;
    chk("first_read_we",   tbl_we_to_pdt, 0);
    chk("first_read_addr", tbl_addr_to_pdt, 20);
    repeat (8) @(posedge clk);
    #1;
    chk("drain_init_q", sb.size(), 0);

    // Spaced taken commits to idx 4: 01 -> 10 -> 11 -> 11 (saturated).
    expect_wr(8'd4, 2'b10);
    expect_wr(8'd4, 2'b11);
    expect_wr(8'd4, 2'b11);
    for (int k = 0; k < 3; k++) begin
      commit(32'h0000_0010, 1'b1);
      repeat (3) @(posedge clk);
      #1;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("drain_taken", sb.size(), 0);

    // Back-to-back not-taken to idx 4: 11 -> 10 -> 01 -> 00 -> 00.
    expect_wr(8'd4, 2'b10);
    expect_wr(8'd4, 2'b01);
    expect_wr(8'd4, 2'b00);
    expect_wr(8'd4, 2'b00);
    for (int k = 0; k < 4; k++) commit(32'h0000_0010, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("drain_nt",  sb.size(), 0);
    chk("nt_full",   full_to_rob, 0);
    chk("nt_ovf",    overflow_err, 0);

    // Reset while the write phase of an update is on the port.
    commit(32'h0000_0020, 1'b1);
    for (int i = 0; i < 6 && !tbl_we_to_pdt; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_upd_we",    tbl_we_to_pdt, 1);
    chk("mid_upd_addr",  tbl_addr_to_pdt, 8);
    chk("mid_upd_wdata", tbl_wdata_to_pdt, 2'b10);
    rst = 1'b0;
    #1;
    check_reset("rst_upd");

    // Reset during the sweep at index 100.
    repeat (2) @(posedge clk);
    push_sweep();
    @(negedge clk) rst = 1'b1;
    repeat (101) @(posedge clk);
    #1;
    chk("sweep100_we",   tbl_we_to_pdt, 1);
    chk("sweep100_addr", tbl_addr_to_pdt, 100);
    @(negedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    check_reset("rst_sweep");
    repeat (2) @(posedge clk);

    // Restarted sweep; fill the queue during INIT and overflow it.
    push_sweep();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_addr", tbl_addr_to_pdt, 0);
    chk("restart_we",   tbl_we_to_pdt, 1);
    repeat (9) @(posedge clk);
    #1;
    expect_wr(8'd4, 2'b10);
    expect_wr(8'd4, 2'b11);
    expect_wr(8'd4, 2'b11);
    expect_wr(8'd7, 2'b00);
    commit(32'h0000_0010, 1'b1);
    commit(32'h0000_0010, 1'b1);
    commit(32'h0000_0010, 1'b1);
    chk("q3_full", full_to_rob, 0);
    commit(32'h0000_001C, 1'b0);
    chk("q4_full", full_to_rob, 1);
    chk("q4_ovf",  overflow_err, 0);
    commit(32'h0000_0024, 1'b1);
    chk("ovf_set",  overflow_err, 1);
    chk("ovf_full", full_to_rob, 1);
    wait_ready();
    repeat (15) @(posedge clk);
    #1;
    chk("drain_final", sb.size(), 0);
    chk("final_full",  full_to_rob, 0);
    chk("ovf_sticky",  overflow_err, 1);
    chk("final_ready", ready_to_fch, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
